// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: forwarding, ALU, iterative multiplier FSM, EX/MEM register
module ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ID_EX_Valid,
    input  logic [3:0]        ID_EX_ALUOp,
    input  logic [DATA_W-1:0] ID_EX_RsData,
    input  logic [DATA_W-1:0] ID_EX_RtData,
    input  logic [DATA_W-1:0] ID_EX_Imm,
    input  logic              ID_EX_ALUSrc,
    input  logic              ID_EX_RegWrite,
    input  logic              ID_EX_MemRead,
    input  logic              ID_EX_MemWrite,
    input  logic [4:0]        ID_EX_RdAddr,
    input  logic [1:0]        ForwardA,
    input  logic [1:0]        ForwardB,
    input  logic [DATA_W-1:0] MEM_WB_WriteData,
    input  logic              Flush,
    output logic              Stall,
    output logic              EX_MEM_Valid,
    output logic              EX_MEM_RegWrite,
    output logic              EX_MEM_MemRead,
    output logic              EX_MEM_MemWrite,
    output logic [4:0]        EX_MEM_RdAddr,
    output logic [DATA_W-1:0] EX_MEM_ALUResult,
    output logic [DATA_W-1:0] EX_MEM_StoreData
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [3:0] OP_MUL = 4'd12;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  mcand, mplier, prod;
    logic [DATA_W-1:0]  op_a, fwd_b, op_b, alu_res;
    logic               mul_start, stall_int;
    logic [4:0]         shamt;

    assign mul_start = ID_EX_Valid && (ID_EX_ALUOp == OP_MUL);
    assign shamt     = op_b[4:0];
    // Reset must never hold the front end, whatever sits in ID/EX.
    assign Stall     = stall_int && rst_n;

    // Operand selection from the forwarding unit; 11 falls back to the register file.
    always_comb begin
        op_a  = ID_EX_RsData;
        fwd_b = ID_EX_RtData;
        case (ForwardA)
            2'b10:   op_a = EX_MEM_ALUResult;
            2'b01:   op_a = MEM_WB_WriteData;
            default: op_a = ID_EX_RsData;
        endcase
        case (ForwardB)
            2'b10:   fwd_b = EX_MEM_ALUResult;
            2'b01:   fwd_b = MEM_WB_WriteData;
            default: fwd_b = ID_EX_RtData;
        endcase
        op_b = ID_EX_ALUSrc ? ID_EX_Imm : fwd_b;
    end

    // Single-cycle ALU; MUL yields 0 here because its product comes from the FSM.
    always_comb begin
        alu_res = '0;
        case (ID_EX_ALUOp)
            4'd0:  alu_res = op_a + op_b;
            4'd1:  alu_res = op_a - op_b;
            4'd2:  alu_res = op_a & op_b;
            4'd3:  alu_res = op_a | op_b;
            4'd4:  alu_res = op_a ^ op_b;
            4'd5:  alu_res = ~(op_a | op_b);
            4'd6:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd7:  alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            4'd8:  alu_res = op_a << shamt;
            4'd9:  alu_res = op_a >> shamt;
            4'd10: alu_res = $signed(op_a) >>> shamt;
            4'd11: alu_res = op_b << 16;
            default: alu_res = '0;
        endcase
    end

    // Multiplier FSM next state and stall; Flush wins over everything.
    always_comb begin
        state_nxt = state;
        stall_int = 1'b0;
        if (Flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        stall_int = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    stall_int = 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1))
                        state_nxt = DONE;
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register plus shift-add datapath; operands are latched once at start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else begin
            state <= state_nxt;
            if (Flush) begin
                cnt <= '0;
            end else if (state == IDLE && mul_start) begin
                mcand  <= op_a;
                mplier <= op_b;
                prod   <= '0;
                cnt    <= '0;
            end else if (state == BUSY) begin
                if (mplier[0])
                    prod <= prod + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end

    // EX/MEM register: bubble on flush, stall or empty slot; product when DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EX_MEM_Valid     <= 1'b0;
            EX_MEM_RegWrite  <= 1'b0;
            EX_MEM_MemRead   <= 1'b0;
            EX_MEM_MemWrite  <= 1'b0;
            EX_MEM_RdAddr    <= '0;
            EX_MEM_ALUResult <= '0;
            EX_MEM_StoreData <= '0;
        end else if (Flush || stall_int || !ID_EX_Valid) begin
            EX_MEM_Valid     <= 1'b0;
            EX_MEM_RegWrite  <= 1'b0;
            EX_MEM_MemRead   <= 1'b0;
            EX_MEM_MemWrite  <= 1'b0;
            EX_MEM_RdAddr    <= '0;
            EX_MEM_ALUResult <= '0;
            EX_MEM_StoreData <= '0;
        end else begin
            EX_MEM_Valid     <= 1'b1;
            EX_MEM_RegWrite  <= ID_EX_RegWrite;
            EX_MEM_MemRead   <= ID_EX_MemRead;
            EX_MEM_MemWrite  <= ID_EX_MemWrite;
            EX_MEM_RdAddr    <= ID_EX_RdAddr;
            EX_MEM_ALUResult <= (state == DONE) ? prod : alu_res;
            EX_MEM_StoreData <= fwd_b;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed-vector testbench for ex_stage
module tb_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        ID_EX_Valid;
    logic [3:0]  ID_EX_ALUOp;
    logic [31:0] ID_EX_RsData, ID_EX_RtData, ID_EX_Imm;
    logic        ID_EX_ALUSrc;
    logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite;
    logic [4:0]  ID_EX_RdAddr;
    logic [1:0]  ForwardA, ForwardB;
    logic [31:0] MEM_WB_WriteData;
    logic        Flush;
    logic        Stall;
    logic        EX_MEM_Valid, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite;
    logic [4:0]  EX_MEM_RdAddr;
    logic [31:0] EX_MEM_ALUResult, EX_MEM_StoreData;

    int vecs = 0;
    int errs = 0;

    ex_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_EX_Valid(ID_EX_Valid), .ID_EX_ALUOp(ID_EX_ALUOp),
        .ID_EX_RsData(ID_EX_RsData), .ID_EX_RtData(ID_EX_RtData), .ID_EX_Imm(ID_EX_Imm),
        .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
        .ID_EX_RdAddr(ID_EX_RdAddr), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .MEM_WB_WriteData(MEM_WB_WriteData), .Flush(Flush), .Stall(Stall),
        .EX_MEM_Valid(EX_MEM_Valid), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_RdAddr(EX_MEM_RdAddr), .EX_MEM_ALUResult(EX_MEM_ALUResult),
        .EX_MEM_StoreData(EX_MEM_StoreData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic src, input logic [4:0] rd);
        ID_EX_Valid = 1'b1; ID_EX_ALUOp = op; ID_EX_RsData = rs; ID_EX_RtData = rt;
        ID_EX_Imm = imm; ID_EX_ALUSrc = src; ID_EX_RdAddr = rd;
        ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b0; ID_EX_MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Flush = 1'b0; ForwardA = 2'b00; ForwardB = 2'b00; MEM_WB_WriteData = '0;
        drive(4'd12, 32'd3, 32'd4, 32'd0, 1'b0, 5'd9);
        #1;
        vecs++;
        if ({EX_MEM_Valid, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RdAddr,
             EX_MEM_ALUResult, EX_MEM_StoreData, Stall} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got valid=%b res=%h stall=%b, expected all 0",
                     EX_MEM_Valid, EX_MEM_ALUResult, Stall);
        end
        ID_EX_Valid = 1'b0;
        step();
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        drive(4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3);
        #1;
        vecs++;
        if (EX_MEM_RegWrite !== 1'b0) begin
            errs++; $display("FAIL add_pre_edge_regwrite: got %b, expected 0", EX_MEM_RegWrite);
        end
        step();
        vecs++;
        if (EX_MEM_ALUResult !== 32'd12 || EX_MEM_RegWrite !== 1'b1 || EX_MEM_Valid !== 1'b1 ||
            EX_MEM_RdAddr !== 5'd3 || EX_MEM_StoreData !== 32'd7) begin
            errs++;
            $display("FAIL add: got res=%0d rw=%b v=%b rd=%0d sd=%0d, expected 12 1 1 3 7",
                     EX_MEM_ALUResult, EX_MEM_RegWrite, EX_MEM_Valid, EX_MEM_RdAddr, EX_MEM_StoreData);
        end
    endtask

    task automatic test_forward();
        drive(4'd1, 32'd100, 32'd200, 32'd0, 1'b0, 5'd4);
        ForwardA = 2'b10; ForwardB = 2'b01; MEM_WB_WriteData = 32'd3;
        step();
        vecs++;
        if (EX_MEM_ALUResult !== 32'd9 || EX_MEM_StoreData !== 32'd3) begin
            errs++;
            $display("FAIL fwd_sub: got res=%0d sd=%0d, expected 9 3", EX_MEM_ALUResult, EX_MEM_StoreData);
        end
        drive(4'd1, 32'd20, 32'd5, 32'd0, 1'b0, 5'd4);
        ForwardA = 2'b11; ForwardB = 2'b00;
        step();
        vecs++;
        if (EX_MEM_ALUResult !== 32'd15) begin
            errs++; $display("FAIL fwd_11_uses_rs: got %0d, expected 15", EX_MEM_ALUResult);
        end
        ForwardA = 2'b00;
        drive(4'd0, 32'd1, 32'd99, 32'h10, 1'b1, 5'd5);
        step();
        vecs++;
        if (EX_MEM_ALUResult !== 32'd17 || EX_MEM_StoreData !== 32'd99) begin
            errs++;
            $display("FAIL alusrc_imm: got res=%0d sd=%0d, expected 17 99", EX_MEM_ALUResult, EX_MEM_StoreData);
        end
    endtask

    task automatic test_alu();
        logic [3:0]  ops [12] = '{4'd6, 4'd7, 4'd10, 4'd11, 4'd2, 4'd3, 4'd4, 4'd5,
                                  4'd8, 4'd9, 4'd13, 4'd0};
        logic [31:0] as  [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h0,
                                  32'hF0F0, 32'hF0F0, 32'hFF00, 32'h0F0F0F0F,
                                  32'h1, 32'h80000000, 32'h12345678, 32'hFFFFFFFF};
        logic [31:0] bs  [12] = '{32'd1, 32'd1, 32'd4, 32'h1234,
                                  32'h0FF0, 32'h0FF0, 32'h0FF0, 32'hF0F0F0F0,
                                  32'd31, 32'd4, 32'd1, 32'd1};
        logic [31:0] exp [12] = '{32'd1, 32'd0, 32'hF8000000, 32'h12340000,
                                  32'h00F0, 32'hFFF0, 32'hF0F0, 32'h0,
                                  32'h80000000, 32'h08000000, 32'h0, 32'h0};
        for (int i = 0; i < 12; i++) begin
            drive(ops[i], as[i], 32'd0, bs[i], 1'b1, 5'd6);
            step();
            vecs++;
            if (EX_MEM_ALUResult !== exp[i]) begin
                errs++;
                $display("FAIL alu_op%0d: got %h, expected %h", ops[i], EX_MEM_ALUResult, exp[i]);
            end
        end
    endtask

    task automatic test_bubble();
        drive(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd7);
        ID_EX_Valid = 1'b0;
        step();
        vecs++;
        if ({EX_MEM_Valid, EX_MEM_RegWrite, EX_MEM_RdAddr, EX_MEM_ALUResult, EX_MEM_StoreData} !== '0) begin
            errs++;
            $display("FAIL invalid_bubble: got v=%b rw=%b res=%h, expected 0", EX_MEM_Valid,
                     EX_MEM_RegWrite, EX_MEM_ALUResult);
        end
    endtask

    task automatic test_mul();
        int stall_cycles = 0;
        int bad_bubbles = 0;
        drive(4'd12, 32'h0000FFFF, 32'h00010001, 32'd0, 1'b0, 5'd7);
        #1;
        if (Stall === 1'b1) stall_cycles++;
        for (int e = 1; e <= 33; e++) begin
            step();
            if (EX_MEM_Valid !== 1'b0 || EX_MEM_ALUResult !== 32'd0 || EX_MEM_RdAddr !== 5'd0)
                bad_bubbles++;
            if (Stall === 1'b1) stall_cycles++;
            if (e == 5) begin
                ForwardA = 2'b01; ForwardB = 2'b01; MEM_WB_WriteData = 32'hDEADBEEF;
            end
        end
        vecs++;
        if (stall_cycles != 33) begin
            errs++; $display("FAIL mul_stall_cycles: got %0d, expected 33", stall_cycles);
        end
        vecs++;
        if (bad_bubbles != 0) begin
            errs++; $display("FAIL mul_bubbles: got %0d non-bubble edges, expected 0", bad_bubbles);
        end
        step();
        vecs++;
        if (EX_MEM_ALUResult !== 32'hFFFFFFFF || EX_MEM_Valid !== 1'b1 || EX_MEM_RdAddr !== 5'd7) begin
            errs++;
            $display("FAIL mul_product_edge34: got res=%h v=%b rd=%0d, expected ffffffff 1 7",
                     EX_MEM_ALUResult, EX_MEM_Valid, EX_MEM_RdAddr);
        end
        ForwardA = 2'b00; ForwardB = 2'b00; ID_EX_Valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ma [2] = '{32'd3, 32'd7};
        logic [31:0] mb [2] = '{32'd5, 32'd6};
        logic [31:0] mp [2] = '{32'd15, 32'd42};
        for (int k = 0; k < 2; k++) begin
            int lat = 0;
            drive(4'd12, ma[k], mb[k], 32'd0, 1'b0, 5'd8);
            for (int e = 1; e <= 40 && lat == 0; e++) begin
                step();
                if (EX_MEM_Valid === 1'b1) lat = e;
            end
            vecs++;
            if (lat != 34 || EX_MEM_ALUResult !== mp[k]) begin
                errs++;
                $display("FAIL b2b_mul%0d: got latency=%0d res=%0d, expected 34 %0d",
                         k, lat, EX_MEM_ALUResult, mp[k]);
            end
        end
        ID_EX_Valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        int writes = 0;
        drive(4'd12, 32'd9, 32'd9, 32'd0, 1'b0, 5'd4);
        for (int e = 1; e <= 10; e++) step();
        Flush = 1'b1;
        #1;
        vecs++;
        if (Stall !== 1'b0) begin
            errs++; $display("FAIL flush_cycle_stall: got %b, expected 0", Stall);
        end
        step();
        Flush = 1'b0; ID_EX_Valid = 1'b0;
        #1;
        vecs++;
        if (Stall !== 1'b0 || EX_MEM_Valid !== 1'b0 || EX_MEM_ALUResult !== 32'd0) begin
            errs++;
            $display("FAIL flush_bubble: got stall=%b v=%b res=%h, expected 0 0 0",
                     Stall, EX_MEM_Valid, EX_MEM_ALUResult);
        end
        for (int e = 0; e < 40; e++) begin
            step();
            if (EX_MEM_Valid === 1'b1) writes++;
        end
        vecs++;
        if (writes != 0) begin
            errs++; $display("FAIL flush_no_product: got %0d writes, expected 0", writes);
        end
        drive(4'd0, 32'd2, 32'd2, 32'd0, 1'b0, 5'd2);
        step();
        vecs++;
        if (EX_MEM_ALUResult !== 32'd4 || EX_MEM_Valid !== 1'b1) begin
            errs++;
            $display("FAIL flush_then_add: got res=%0d v=%b, expected 4 1", EX_MEM_ALUResult, EX_MEM_Valid);
        end
    endtask

    task automatic test_reset_mid();
        int writes = 0;
        drive(4'd12, 32'd11, 32'd13, 32'd0, 1'b0, 5'd9);
        for (int e = 1; e <= 20; e++) step();
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if ({EX_MEM_Valid, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RdAddr,
             EX_MEM_ALUResult, EX_MEM_StoreData, Stall} !== '0) begin
            errs++;
            $display("FAIL async_reset_mid_mul: got v=%b res=%h stall=%b, expected all 0",
                     EX_MEM_Valid, EX_MEM_ALUResult, Stall);
        end
        drive(4'd0, 32'd10, 32'd20, 32'd0, 1'b0, 5'd1);
        step();
        #2 rst_n = 1'b1;
        step();
        vecs++;
        if (EX_MEM_ALUResult !== 32'd30 || EX_MEM_Valid !== 1'b1 || EX_MEM_RdAddr !== 5'd1) begin
            errs++;
            $display("FAIL add_after_reset: got res=%0d v=%b rd=%0d, expected 30 1 1",
                     EX_MEM_ALUResult, EX_MEM_Valid, EX_MEM_RdAddr);
        end
        ID_EX_Valid = 1'b0;
        for (int e = 0; e < 40; e++) begin
            step();
            if (EX_MEM_Valid === 1'b1) writes++;
        end
        vecs++;
        if (writes != 0) begin
            errs++; $display("FAIL reset_no_partial: got %0d writes, expected 0", writes);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_forward();
        test_alu();
        test_bubble();
        test_mul();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
